tx_dsc_reader: RTL and testbench
================================

TX_DSC_READER -- requirements
Module: tx_dsc_reader

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, descriptor output FIFO entries (power of two, >= MAX_BURST).
REQ-002 Parameter MAX_BURST, default 8, max descriptors per PCIe read burst (1..8).
REQ-003 pcie_clk  in  1  sole clock.
REQ-004 pcie_reset_n  in  1  asynchronous active-low reset.
REQ-005 sw_reset  in  1  software ring reset, synchronous, level.
REQ-006 rb_base_addr  in  64  host physical address of TX descriptor ring, 64 B aligned.
REQ-007 rb_size  in  26  ring size in descriptors, power of two, >= 2.
REQ-008 tail_wr  in  1  one-cycle pulse: software wrote TX tail.
REQ-009 tail_wr_data  in  32  new tail index.
REQ-010 pcie_bas_waitrequest  in  1; pcie_bas_address  out  64; pcie_bas_read  out  1; pcie_bas_burstcount  out  4; pcie_bas_byteenable  out  64; pcie_bas_readdata  in  512; pcie_bas_readdatavalid  in  1; pcie_bas_response  in  2: Avalon-MM read master.
REQ-011 out_dsc_data  out  tx_dsc_t  descriptor (addr 64 b = bytes 0-7, length 32 b = bytes 8-11).
REQ-012 out_dsc_valid  out  1; out_dsc_ready  in  1: ready/valid stream.
REQ-013 head  out  32  index of next descriptor to fetch.
REQ-014 rd_err_cnt  out  32  beats received with non-zero response.

Function
REQ-015 tail register := tail_wr_data & (rb_size-1) on tail_wr; visible next cycle.
REQ-016 States IDLE, REQ, DATA; one outstanding burst at a time.
REQ-017 IDLE -> REQ when pending = (tail-head) & (rb_size-1) != 0 and FIFO free slots >= 1; pcie_bas_read asserted the cycle after entering the decision, i.e. earliest cycle N+2 after tail_wr in cycle N.
REQ-018 Burst length L = min(pending, rb_size-head, MAX_BURST, FIFO free slots minus beats in flight); bursts never cross ring end.
REQ-019 In REQ: address = rb_base_addr + head*64, burstcount = L, byteenable all ones, read held with constant outputs until waitrequest low; then -> DATA.
REQ-020 In DATA: each readdatavalid beat pushes one descriptor into FIFO; after L-th beat head := (head+L) & (rb_size-1), -> IDLE.
REQ-021 Beat with pcie_bas_response != 0: not pushed, rd_err_cnt += 1 (saturating), still counts toward L and head.
REQ-022 FIFO never overflows: slots for the whole burst are reserved at REQ entry.
REQ-023 tail_wr during REQ/DATA updates tail only; new pending used at next IDLE decision.
REQ-024 tail == head after wrap: ring empty, no read issued.
REQ-025 Output: out_dsc_valid = FIFO non-empty; pop on valid & ready; first-word-fall-through, descriptor visible the cycle after push.
REQ-026 sw_reset in IDLE: head, tail, FIFO, rd_err_cnt cleared next cycle; in REQ/DATA: burst completes, beats discarded, clear on return to IDLE; no read issued while sw_reset high.

Reset
REQ-027 On pcie_reset_n low, asynchronously: state IDLE, head 0, tail 0, FIFO empty, pcie_bas_read 0, pcie_bas_burstcount 0, pcie_bas_address 0, out_dsc_valid 0, rd_err_cnt 0.
REQ-028 Reset mid-burst abandons the burst; late readdatavalid beats after release while IDLE are ignored.

Structure
REQ-029 tx_dsc_t and TX ring constants (descriptor size 64 B) reside in the shared constants package.
REQ-030 Output buffering uses one sub-module, tx_dsc_fifo (synchronous FWFT FIFO with occupancy output).

Verification
REQ-031 rb_size 16, tail_wr 3 -> one read, address base, burstcount 3; 3 descriptors out in order; head 3.
REQ-032 head 14, tail_wr 4 (rb_size 16) -> bursts of 2 at base+14*64 then 4 at base; head 4.
REQ-033 tail_wr 12, out_dsc_ready 0, FIFO_DEPTH 16 -> bursts 8 then 4; no further read until pops; 12 valid descriptors held, none lost.
REQ-034 waitrequest high 5 cycles during REQ -> address/burstcount/read stable all 5 cycles, single accepted request.
REQ-035 Beat 2 of 4 with response 2'b10 -> 3 descriptors out, rd_err_cnt 1, head +4.
REQ-036 pcie_reset_n low during DATA -> all outputs at reset values immediately; after release, tail_wr 1 -> normal burst of 1 at base.

Source files
------------

// File: rtl/tx_dsc_reader_pkg.sv
// Shared TX descriptor ring constants and the descriptor record carried on the output stream.
// Host descriptors are little-endian: bytes 0-7 buffer address, bytes 8-11 length.
package tx_dsc_reader_pkg;

    localparam int unsigned TX_DSC_BYTES = 64;
    localparam int unsigned TX_DSC_SHIFT = 6;
    localparam int unsigned TX_BEAT_W    = 512;

    typedef struct packed {
        logic [31:0] length;
        logic [63:0] addr;
    } tx_dsc_t;

    localparam int unsigned TX_DSC_W = $bits(tx_dsc_t);

    function automatic tx_dsc_t tx_dsc_unpack(input logic [TX_BEAT_W-1:0] beat);
        tx_dsc_t d;
        d.addr   = beat[63:0];
        d.length = beat[95:64];
        return d;
    endfunction

endpackage

// File: rtl/tx_dsc_reader_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and synchronous clear.
// DEPTH must be a power of two, at least 2.
module tx_dsc_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 96
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q != FULL_CNT);
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/tx_dsc_reader.sv
// TX descriptor ring reader: fetches descriptors between head and the software tail over an
// Avalon-MM burst read master and presents them on a ready/valid stream through a FWFT FIFO.
module tx_dsc_reader
    import tx_dsc_reader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic           pcie_clk,
    input  logic           pcie_reset_n,
    input  logic           sw_reset,
    input  logic [63:0]    rb_base_addr,
    input  logic [25:0]    rb_size,
    input  logic           tail_wr,
    input  logic [31:0]    tail_wr_data,
    input  logic           pcie_bas_waitrequest,
    output logic [63:0]    pcie_bas_address,
    output logic           pcie_bas_read,
    output logic [3:0]     pcie_bas_burstcount,
    output logic [63:0]    pcie_bas_byteenable,
    input  logic [511:0]   pcie_bas_readdata,
    input  logic           pcie_bas_readdatavalid,
    input  logic [1:0]     pcie_bas_response,
    output tx_dsc_t        out_dsc_data,
    output logic           out_dsc_valid,
    input  logic           out_dsc_ready,
    output logic [31:0]    head,
    output logic [31:0]    rd_err_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    state_q, state_d;
    logic [31:0]   head_q, head_d, tail_q, tail_d;
    logic [63:0]   addr_q, addr_d;
    logic [3:0]    burst_q, burst_d;
    logic [3:0]    beats_q, beats_d;
    logic [31:0]   err_q, err_d;
    logic          swr_pend_q, swr_pend_d;

    logic [31:0]   ring_mask, pending, to_end, free_slots, len_min;
    logic [3:0]    burst_len;
    logic [CW-1:0] fifo_count;
    logic          fifo_push, fifo_clr, fifo_pop, discard;

    assign ring_mask  = {6'd0, rb_size - 26'd1};
    assign pending    = (tail_q - head_q) & ring_mask;
    assign to_end     = {6'd0, rb_size} - head_q;
    assign free_slots = 32'(FIFO_DEPTH) - 32'(fifo_count);

    // Only one burst is ever outstanding, so in IDLE the free slots already account for in-flight beats.
    always_comb begin
        len_min = pending;
        if (to_end < len_min)            len_min = to_end;
        if (32'(MAX_BURST) < len_min)    len_min = 32'(MAX_BURST);
        if (free_slots < len_min)        len_min = free_slots;
        burst_len = (len_min > 32'd15) ? 4'hF : len_min[3:0];
    end

    assign discard = swr_pend_q || sw_reset;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        addr_d     = addr_q;
        burst_d    = burst_q;
        beats_d    = beats_q;
        err_d      = err_q;
        swr_pend_d = swr_pend_q;
        fifo_push  = 1'b0;
        fifo_clr   = 1'b0;

        if (tail_wr) tail_d = tail_wr_data & ring_mask;

        case (state_q)
            ST_IDLE: begin
                if (sw_reset) begin
                    head_d   = '0;
                    tail_d   = '0;
                    err_d    = '0;
                    fifo_clr = 1'b1;
                end else if ((pending != '0) && (free_slots != '0)) begin
                    state_d = ST_REQ;
                    addr_d  = rb_base_addr + (64'(head_q) << TX_DSC_SHIFT);
                    burst_d = burst_len;
                end
            end
            ST_REQ: begin
                if (sw_reset) swr_pend_d = 1'b1;
                if (!pcie_bas_waitrequest) begin
                    state_d = ST_DATA;
                    beats_d = '0;
                end
            end
            ST_DATA: begin
                if (sw_reset) swr_pend_d = 1'b1;
                if (pcie_bas_readdatavalid) begin
                    if (pcie_bas_response != 2'b00) begin
                        if (err_q != '1) err_d = err_q + 32'd1;
                    end else if (!discard) begin
                        fifo_push = 1'b1;
                    end
                    beats_d = beats_q + 4'd1;
                    if ((beats_q + 4'd1) == burst_q) begin
                        state_d = ST_IDLE;
                        head_d  = (head_q + 32'(burst_q)) & ring_mask;
                        // A software reset seen during the burst takes effect as the burst retires.
                        if (discard) begin
                            head_d     = '0;
                            tail_d     = '0;
                            err_d      = '0;
                            fifo_clr   = 1'b1;
                            swr_pend_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pcie_clk or negedge pcie_reset_n) begin
        if (!pcie_reset_n) begin
            state_q    <= ST_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            addr_q     <= '0;
            burst_q    <= '0;
            beats_q    <= '0;
            err_q      <= '0;
            swr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            beats_q    <= beats_d;
            err_q      <= err_d;
            swr_pend_q <= swr_pend_d;
        end
    end

    assign pcie_bas_read       = (state_q == ST_REQ);
    assign pcie_bas_address    = addr_q;
    assign pcie_bas_burstcount = burst_q;
    assign pcie_bas_byteenable = '1;
    assign head                = head_q;
    assign rd_err_cnt          = err_q;
    assign fifo_pop            = out_dsc_valid && out_dsc_ready;

    tx_dsc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TX_DSC_W)
    ) u_fifo (
        .clk_i   (pcie_clk),
        .rst_n_i (pcie_reset_n),
        .clr_i   (fifo_clr),
        .push_i  (fifo_push),
        .din_i   (tx_dsc_unpack(pcie_bas_readdata)),
        .pop_i   (fifo_pop),
        .dout_o  (out_dsc_data),
        .valid_o (out_dsc_valid),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_tx_dsc_reader.sv
// Directed bench for tx_dsc_reader: a small Avalon read slave returns descriptors whose
// contents encode their ring index; each scenario task checks its own expectations.
`timescale 1ns/1ps
module tb_tx_dsc_reader;
    import tx_dsc_reader_pkg::*;

    localparam logic [63:0] BASE = 64'h0000_0012_3400_0000;

    logic           pcie_clk = 1'b0;
    logic           pcie_reset_n = 1'b0;
    logic           sw_reset = 1'b0;
    logic [63:0]    rb_base_addr = BASE;
    logic [25:0]    rb_size = 26'd16;
    logic           tail_wr = 1'b0;
    logic [31:0]    tail_wr_data = '0;
    logic           pcie_bas_waitrequest = 1'b0;
    logic [63:0]    pcie_bas_address;
    logic           pcie_bas_read;
    logic [3:0]     pcie_bas_burstcount;
    logic [63:0]    pcie_bas_byteenable;
    logic [511:0]   pcie_bas_readdata = '0;
    logic           pcie_bas_readdatavalid = 1'b0;
    logic [1:0]     pcie_bas_response = 2'b00;
    tx_dsc_t        out_dsc_data;
    logic           out_dsc_valid;
    logic           out_dsc_ready = 1'b1;
    logic [31:0]    head;
    logic [31:0]    rd_err_cnt;

    int checks = 0;
    int errors = 0;
    tx_dsc_t got_q[$];

    tx_dsc_reader #(.FIFO_DEPTH(16), .MAX_BURST(8)) dut (
        .pcie_clk               (pcie_clk),
        .pcie_reset_n           (pcie_reset_n),
        .sw_reset               (sw_reset),
        .rb_base_addr           (rb_base_addr),
        .rb_size                (rb_size),
        .tail_wr                (tail_wr),
        .tail_wr_data           (tail_wr_data),
        .pcie_bas_waitrequest   (pcie_bas_waitrequest),
        .pcie_bas_address       (pcie_bas_address),
        .pcie_bas_read          (pcie_bas_read),
        .pcie_bas_burstcount    (pcie_bas_burstcount),
        .pcie_bas_byteenable    (pcie_bas_byteenable),
        .pcie_bas_readdata      (pcie_bas_readdata),
        .pcie_bas_readdatavalid (pcie_bas_readdatavalid),
        .pcie_bas_response      (pcie_bas_response),
        .out_dsc_data           (out_dsc_data),
        .out_dsc_valid          (out_dsc_valid),
        .out_dsc_ready          (out_dsc_ready),
        .head                   (head),
        .rd_err_cnt             (rd_err_cnt)
    );

    always #5 pcie_clk = ~pcie_clk;

    // Every accepted stream transfer, in order.
    always @(negedge pcie_clk) begin
        if (pcie_reset_n === 1'b1 && out_dsc_valid === 1'b1 && out_dsc_ready === 1'b1)
            got_q.push_back(out_dsc_data);
    end

    function automatic logic [511:0] make_beat(input int idx);
        logic [511:0] b;
        b = {16{32'hDEADBEEF}};
        b[63:0]  = 64'hD5C0_0000_0000_0000 | 64'(idx);
        b[95:64] = 32'h0000_0100 + 32'(idx);
        return b;
    endfunction

    function automatic tx_dsc_t exp_dsc(input int idx);
        tx_dsc_t d;
        d.addr   = 64'hD5C0_0000_0000_0000 | 64'(idx);
        d.length = 32'h0000_0100 + 32'(idx);
        return d;
    endfunction

    task automatic tick();
        @(posedge pcie_clk);
        #1;
    endtask

    task automatic write_tail(input int t);
        tail_wr      = 1'b1;
        tail_wr_data = 32'(t);
        tick();
        tail_wr      = 1'b0;
    endtask

    task automatic serve_burst(input int wait_cycles, input int err_beat,
                               output logic [63:0] addr, output int bc);
        int n;
        int base_idx;
        pcie_bas_waitrequest = (wait_cycles > 0);
        n = 0;
        while (pcie_bas_read !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (pcie_bas_read !== 1'b1) begin
            errors++;
            $display("FAIL read_timeout: read=%b required 1", pcie_bas_read);
            addr = '0;
            bc = 0;
            pcie_bas_waitrequest = 1'b0;
            return;
        end
        addr = pcie_bas_address;
        bc   = int'(pcie_bas_burstcount);
        for (int k = 0; k < wait_cycles; k++) begin
            tick();
            checks++;
            if (pcie_bas_read !== 1'b1 || pcie_bas_address !== addr ||
                pcie_bas_burstcount !== bc[3:0]) begin
                errors++;
                $display("FAIL req_hold: cycle %0d read=%b addr=%h bc=%0d required 1 %h %0d",
                         k, pcie_bas_read, pcie_bas_address, pcie_bas_burstcount, addr, bc);
            end
        end
        pcie_bas_waitrequest = 1'b0;
        tick();
        checks++;
        if (pcie_bas_read !== 1'b0) begin
            errors++;
            $display("FAIL req_single: read=%b after accept required 0", pcie_bas_read);
        end
        base_idx = int'((addr - BASE) >> 6);
        for (int b = 0; b < bc; b++) begin
            pcie_bas_readdatavalid = 1'b1;
            pcie_bas_readdata      = make_beat(base_idx + b);
            pcie_bas_response      = (b == err_beat) ? 2'b10 : 2'b00;
            tick();
        end
        pcie_bas_readdatavalid = 1'b0;
        pcie_bas_response      = 2'b00;
    endtask

    task automatic test_reset();
        pcie_reset_n = 1'b0;
        repeat (2) tick();
        checks++; if (pcie_bas_read !== 1'b0) begin errors++; $display("FAIL rst_read: got %b required 0", pcie_bas_read); end
        checks++; if (pcie_bas_burstcount !== 4'd0) begin errors++; $display("FAIL rst_bc: got %0d required 0", pcie_bas_burstcount); end
        checks++; if (pcie_bas_address !== 64'd0) begin errors++; $display("FAIL rst_addr: got %h required 0", pcie_bas_address); end
        checks++; if (out_dsc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", out_dsc_valid); end
        checks++; if (head !== 32'd0) begin errors++; $display("FAIL rst_head: got %0d required 0", head); end
        checks++; if (rd_err_cnt !== 32'd0) begin errors++; $display("FAIL rst_err: got %0d required 0", rd_err_cnt); end
        pcie_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [63:0] a;
        int bc;
        got_q.delete();
        out_dsc_ready = 1'b1;
        write_tail(3);
        checks++; if (pcie_bas_read !== 1'b0) begin errors++; $display("FAIL basic_early: read=%b required 0", pcie_bas_read); end
        tick();
        checks++; if (pcie_bas_read !== 1'b1) begin errors++; $display("FAIL basic_latency: read=%b required 1", pcie_bas_read); end
        checks++; if (pcie_bas_byteenable !== {64{1'b1}}) begin errors++; $display("FAIL basic_be: got %h required all ones", pcie_bas_byteenable); end
        serve_burst(0, -1, a, bc);
        checks++; if (a !== BASE) begin errors++; $display("FAIL basic_addr: got %h required %h", a, BASE); end
        checks++; if (bc != 3) begin errors++; $display("FAIL basic_bc: got %0d required 3", bc); end
        repeat (5) tick();
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL basic_count: got %0d required 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_dsc(i)) begin errors++; $display("FAIL basic_dsc%0d: got %h required %h", i, got_q[i], exp_dsc(i)); end
        end
        checks++; if (head !== 32'd3) begin errors++; $display("FAIL basic_head: got %0d required 3", head); end
    endtask

    task automatic test_wrap();
        logic [63:0] a;
        int bc;
        int expi[$];
        logic [63:0] exp_a [4];
        int exp_bc [4];
        exp_a[0] = BASE + 64'd3*64;  exp_bc[0] = 8;
        exp_a[1] = BASE + 64'd11*64; exp_bc[1] = 3;
        exp_a[2] = BASE + 64'd14*64; exp_bc[2] = 2;
        exp_a[3] = BASE;             exp_bc[3] = 4;
        got_q.delete();
        for (int i = 3; i < 14; i++) expi.push_back(i);
        expi.push_back(14); expi.push_back(15);
        for (int i = 0; i < 4; i++) expi.push_back(i);
        write_tail(14);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                checks++; if (head !== 32'd14) begin errors++; $display("FAIL wrap_head14: got %0d required 14", head); end
                write_tail(4);
            end
            serve_burst(0, -1, a, bc);
            checks++; if (a !== exp_a[k]) begin errors++; $display("FAIL wrap_addr%0d: got %h required %h", k, a, exp_a[k]); end
            checks++; if (bc != exp_bc[k]) begin errors++; $display("FAIL wrap_bc%0d: got %0d required %0d", k, bc, exp_bc[k]); end
        end
        repeat (5) tick();
        checks++; if (got_q.size() != expi.size()) begin errors++; $display("FAIL wrap_count: got %0d required %0d", got_q.size(), expi.size()); end
        for (int i = 0; i < expi.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_dsc(expi[i])) begin errors++; $display("FAIL wrap_dsc%0d: got %h required %h", i, got_q[i], exp_dsc(expi[i])); end
        end
        checks++; if (head !== 32'd4) begin errors++; $display("FAIL wrap_head: got %0d required 4", head); end
    endtask

    task automatic test_sw_reset();
        logic [63:0] a;
        int bc;
        bit saw_read;
        out_dsc_ready = 1'b0;
        write_tail(int'((head + 32'd1) & 32'd15));
        serve_burst(0, -1, a, bc);
        tick();
        checks++; if (out_dsc_valid !== 1'b1) begin errors++; $display("FAIL swr_prefill: valid=%b required 1", out_dsc_valid); end
        sw_reset = 1'b1;
        tick();
        sw_reset = 1'b0;
        checks++; if (out_dsc_valid !== 1'b0) begin errors++; $display("FAIL swr_valid: got %b required 0", out_dsc_valid); end
        checks++; if (head !== 32'd0) begin errors++; $display("FAIL swr_head: got %0d required 0", head); end
        checks++; if (rd_err_cnt !== 32'd0) begin errors++; $display("FAIL swr_err: got %0d required 0", rd_err_cnt); end
        saw_read = 1'b0;
        repeat (6) begin
            tick();
            if (pcie_bas_read === 1'b1) saw_read = 1'b1;
        end
        checks++; if (saw_read) begin errors++; $display("FAIL swr_noread: read seen=1 required 0"); end
        out_dsc_ready = 1'b1;
    endtask

    task automatic test_error();
        logic [63:0] a;
        int bc;
        int expi[3];
        expi[0] = 0; expi[1] = 2; expi[2] = 3;
        got_q.delete();
        write_tail(4);
        serve_burst(0, 1, a, bc);
        checks++; if (a !== BASE || bc != 4) begin errors++; $display("FAIL err_req: got %h/%0d required %h/4", a, bc, BASE); end
        repeat (5) tick();
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL err_count: got %0d required 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_dsc(expi[i])) begin errors++; $display("FAIL err_dsc%0d: got %h required %h", i, got_q[i], exp_dsc(expi[i])); end
        end
        checks++; if (rd_err_cnt !== 32'd1) begin errors++; $display("FAIL err_cnt: got %0d required 1", rd_err_cnt); end
        checks++; if (head !== 32'd4) begin errors++; $display("FAIL err_head: got %0d required 4", head); end
    endtask

    task automatic test_backpressure();
        logic [63:0] a;
        int bc;
        bit saw_read;
        got_q.delete();
        out_dsc_ready = 1'b0;
        write_tail(12);
        serve_burst(0, -1, a, bc);
        checks++; if (a !== BASE || bc != 8) begin errors++; $display("FAIL bp_req0: got %h/%0d required %h/8", a, bc, BASE); end
        serve_burst(0, -1, a, bc);
        checks++; if (a !== BASE + 64'd512 || bc != 4) begin errors++; $display("FAIL bp_req1: got %h/%0d required %h/4", a, bc, BASE + 64'd512); end
        saw_read = 1'b0;
        repeat (20) begin
            tick();
            if (pcie_bas_read === 1'b1) saw_read = 1'b1;
        end
        checks++; if (saw_read) begin errors++; $display("FAIL bp_noread: read seen=1 required 0"); end
        checks++; if (out_dsc_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b required 1", out_dsc_valid); end
        checks++; if (head !== 32'd12) begin errors++; $display("FAIL bp_head: got %0d required 12", head); end
        out_dsc_ready = 1'b1;
        repeat (20) tick();
        checks++; if (got_q.size() != 12) begin errors++; $display("FAIL bp_count: got %0d required 12", got_q.size()); end
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_dsc(i)) begin errors++; $display("FAIL bp_dsc%0d: got %h required %h", i, got_q[i], exp_dsc(i)); end
        end
    endtask

    task automatic test_waitrequest();
        logic [63:0] a;
        int bc;
        got_q.delete();
        write_tail(13);
        serve_burst(5, -1, a, bc);
        checks++; if (a !== BASE + 64'd12*64 || bc != 1) begin errors++; $display("FAIL wait_req: got %h/%0d required %h/1", a, bc, BASE + 64'd12*64); end
        repeat (5) tick();
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL wait_count: got %0d required 1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0] !== exp_dsc(12)) begin errors++; $display("FAIL wait_dsc: got %h required %h", got_q[0], exp_dsc(12)); end
        end
        checks++; if (head !== 32'd13) begin errors++; $display("FAIL wait_head: got %0d required 13", head); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] a;
        int bc;
        int n;
        got_q.delete();
        out_dsc_ready = 1'b0;
        write_tail(15);
        n = 0;
        while (pcie_bas_read !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (pcie_bas_read !== 1'b1 || pcie_bas_burstcount !== 4'd2) begin
            errors++; $display("FAIL mid_req: read=%b bc=%0d required 1/2", pcie_bas_read, pcie_bas_burstcount);
        end
        tick();
        pcie_bas_readdatavalid = 1'b1;
        pcie_bas_readdata      = make_beat(13);
        tick();
        pcie_bas_readdatavalid = 1'b0;
        tick();
        checks++; if (out_dsc_valid !== 1'b1) begin errors++; $display("FAIL mid_pushed: valid=%b required 1", out_dsc_valid); end
        pcie_reset_n = 1'b0;
        #1;
        checks++; if (out_dsc_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b required 0", out_dsc_valid); end
        checks++; if (pcie_bas_burstcount !== 4'd0) begin errors++; $display("FAIL mid_bc: got %0d required 0", pcie_bas_burstcount); end
        checks++; if (pcie_bas_address !== 64'd0) begin errors++; $display("FAIL mid_addr: got %h required 0", pcie_bas_address); end
        checks++; if (pcie_bas_read !== 1'b0) begin errors++; $display("FAIL mid_read: got %b required 0", pcie_bas_read); end
        checks++; if (head !== 32'd0) begin errors++; $display("FAIL mid_head: got %0d required 0", head); end
        checks++; if (rd_err_cnt !== 32'd0) begin errors++; $display("FAIL mid_err: got %0d required 0", rd_err_cnt); end
        tick();
        pcie_reset_n = 1'b1;
        tick();
        pcie_bas_readdatavalid = 1'b1;
        pcie_bas_readdata      = make_beat(14);
        tick();
        pcie_bas_readdatavalid = 1'b0;
        tick();
        checks++; if (out_dsc_valid !== 1'b0 || pcie_bas_read !== 1'b0) begin
            errors++; $display("FAIL mid_late: valid=%b read=%b required 0/0", out_dsc_valid, pcie_bas_read);
        end
        out_dsc_ready = 1'b1;
        write_tail(1);
        serve_burst(0, -1, a, bc);
        checks++; if (a !== BASE || bc != 1) begin errors++; $display("FAIL mid_after: got %h/%0d required %h/1", a, bc, BASE); end
        repeat (5) tick();
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL mid_count: got %0d required 1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0] !== exp_dsc(0)) begin errors++; $display("FAIL mid_dsc: got %h required %h", got_q[0], exp_dsc(0)); end
        end
        checks++; if (head !== 32'd1) begin errors++; $display("FAIL mid_head1: got %0d required 1", head); end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_wrap();
        test_sw_reset();
        test_error();
        test_sw_reset();
        test_backpressure();
        test_waitrequest();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
